// File: rtl/hex_display_ctrl.sv
// Binary-to-display feeder: accepts a value via Load/Ready, renders it as hex or
// BCD nibbles (serial double dabble), and drives leading-zero blanking enables.
module hex_display_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [WIDTH-1:0]      Value,
  input  logic                  Decimal,
  input  logic                  Blank_Lz,
  input  logic                  Load,
  output logic                  Ready,
  output logic                  Done,
  output logic                  Ovf,
  output logic [4*DIGITS-1:0]   Digits,
  output logic [DIGITS-1:0]     Digit_En
);

  localparam int NB = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int XW = (WIDTH > NB) ? WIDTH : NB;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [NB-1:0]     bcd_q, bcd_d;
  logic              dec_q, dec_d;
  logic              blz_q, blz_d;
  logic              bovf_q, bovf_d;
  logic [NB-1:0]     digits_q, digits_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [NB-1:0]     adj;
  logic [XW-1:0]     ext;

  function automatic logic [NB-1:0] add3(input logic [NB-1:0] b);
    logic [NB-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Enable every digit at or below the most significant nonzero one; digit 0 always on.
  function automatic logic [DIGITS-1:0] blank_en(input logic [NB-1:0] d, input logic blz);
    logic [DIGITS-1:0] en;
    logic seen;
    seen = 1'b0;
    en   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen  = seen | (d[4*i +: 4] != 4'd0);
      en[i] = seen | ~blz | (i == 0);
    end
    return en;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    dec_d    = dec_q;
    blz_d    = blz_q;
    bovf_d   = bovf_q;
    digits_d = digits_q;
    en_d     = en_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    adj      = add3(bcd_q);
    ext      = XW'(bin_q);
    case (state_q)
      IDLE: begin
        if (Load) begin
          bin_d   = Value;
          dec_d   = Decimal;
          blz_d   = Blank_Lz;
          bcd_d   = '0;
          bovf_d  = 1'b0;
          cnt_d   = '0;
          state_d = Decimal ? CONVERT : COMMIT;
        end
      end
      CONVERT: begin
        // Adjust then shift {bcd, bin}; a bit leaving the BCD MSB is sticky overflow.
        bcd_d  = {adj[NB-2:0], bin_q[WIDTH-1]};
        bovf_d = bovf_q | adj[NB-1];
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        if (dec_q) begin
          digits_d = bcd_q;
          ovf_d    = bovf_q;
        end else begin
          digits_d = ext[NB-1:0];
          ovf_d    = |(ext >> NB);
        end
        en_d    = blank_en(digits_d, blz_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= '0;
      en_q     <= '1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Working registers are always reloaded on Load, so they carry no reset.
  always_ff @(posedge Clk) begin
    bin_q  <= bin_d;
    bcd_q  <= bcd_d;
    dec_q  <= dec_d;
    blz_q  <= blz_d;
    bovf_q <= bovf_d;
  end

  assign Ready    = (state_q == IDLE);
  assign Done     = done_q;
  assign Ovf      = ovf_q;
  assign Digits   = digits_q;
  assign Digit_En = en_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized self-checking bench for hex_display_ctrl with 6-, 4- and 3-digit
// instances driven in parallel and compared against an arithmetic reference model.
module tb_hex_display_ctrl;

  localparam int W = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [W-1:0]  Value;
  logic          Decimal, Blank_Lz, Load;

  logic          RdyA, DoneA, OvfA;
  logic [23:0]   DigA;
  logic [5:0]    EnA;
  logic          RdyB, DoneB, OvfB;
  logic [15:0]   DigB;
  logic [3:0]    EnB;
  logic          RdyC, DoneC, OvfC;
  logic [11:0]   DigC;
  logic [2:0]    EnC;

  always #5 Clk = ~Clk;

  hex_display_ctrl #(.WIDTH(W), .DIGITS(6)) dut_a (
    .Clk(Clk), .Reset(Reset), .Value(Value), .Decimal(Decimal), .Blank_Lz(Blank_Lz),
    .Load(Load), .Ready(RdyA), .Done(DoneA), .Ovf(OvfA), .Digits(DigA), .Digit_En(EnA));
  hex_display_ctrl #(.WIDTH(W), .DIGITS(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Value(Value), .Decimal(Decimal), .Blank_Lz(Blank_Lz),
    .Load(Load), .Ready(RdyB), .Done(DoneB), .Ovf(OvfB), .Digits(DigB), .Digit_En(EnB));
  hex_display_ctrl #(.WIDTH(W), .DIGITS(3)) dut_c (
    .Clk(Clk), .Reset(Reset), .Value(Value), .Decimal(Decimal), .Blank_Lz(Blank_Lz),
    .Load(Load), .Ready(RdyC), .Done(DoneC), .Ovf(OvfC), .Digits(DigC), .Digit_En(EnC));

  int n_err = 0;
  int n_chk = 0;
  logic [23:0] exp_dig [3];
  logic [5:0]  exp_en  [3];
  logic        exp_ovf [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nd_of(input int k);
    return (k == 0) ? 6 : (k == 1) ? 4 : 3;
  endfunction

  // Digits by repeated division in the chosen radix; overflow is any remaining quotient.
  function automatic void model(input int nd, input logic [W-1:0] v, input logic dec,
                                input logic blz, output logic [23:0] dg,
                                output logic [5:0] en, output logic ovf);
    int rest, msd, radix;
    dg    = '0;
    en    = '0;
    rest  = int'(v);
    msd   = 0;
    radix = dec ? 10 : 16;
    for (int i = 0; i < nd; i++) begin
      int d;
      d    = rest % radix;
      rest = rest / radix;
      dg[4*i +: 4] = 4'(d);
      if (d != 0) msd = i;
    end
    ovf = (rest != 0);
    for (int i = 0; i < nd; i++) en[i] = (!blz) || (i <= msd);
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 3; k++) begin
      exp_dig[k] = '0;
      exp_en[k]  = 6'((1 << nd_of(k)) - 1);
      exp_ovf[k] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".dig6"}, 32'(DigA), 32'(exp_dig[0]));
    chk({tag, ".en6"},  32'(EnA),  32'(exp_en[0]));
    chk({tag, ".ovf6"}, 32'(OvfA), 32'(exp_ovf[0]));
    chk({tag, ".dig4"}, 32'(DigB), 32'(exp_dig[1]));
    chk({tag, ".en4"},  32'(EnB),  32'(exp_en[1]));
    chk({tag, ".ovf4"}, 32'(OvfB), 32'(exp_ovf[1]));
    chk({tag, ".dig3"}, 32'(DigC), 32'(exp_dig[2]));
    chk({tag, ".en3"},  32'(EnC),  32'(exp_en[2]));
    chk({tag, ".ovf3"}, 32'(OvfC), 32'(exp_ovf[2]));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
      chk("idle_done", 32'({DoneA, DoneB, DoneC}), 32'd0);
      chk("idle_ready", 32'({RdyA, RdyB, RdyC}), 32'h7);
      chk("idle_dig", 32'(DigA), 32'(exp_dig[0]));
    end
  endtask

  // Called at a sample point; the Load is taken on the next rising edge.
  task automatic start(input logic [W-1:0] v, input logic dec, input logic blz,
                       input logic hold, input logic [W-1:0] hv);
    chk("ready_before_load", 32'(RdyA), 32'd1);
    Value = v; Decimal = dec; Blank_Lz = blz; Load = 1'b1;
    @(posedge Clk); #1;
    if (hold) begin
      Value = hv; Decimal = 1'b1; Blank_Lz = 1'b0;
    end else begin
      Load = 1'b0;
      Value = W'($urandom); Decimal = 1'($urandom); Blank_Lz = 1'($urandom);
    end
    chk("done_low_after_accept", 32'(DoneA), 32'd0);
    chk("busy_after_accept", 32'({RdyA, RdyB, RdyC}), 32'd0);
  endtask

  task automatic finish(input logic [W-1:0] v, input logic dec, input logic blz);
    int edges, lat;
    edges = 0;
    lat   = dec ? W + 1 : 1;
    while (!DoneA && edges < W + 10) begin
      chk("hold_dig", 32'(DigA), 32'(exp_dig[0]));
      chk("busy_ready", 32'(RdyA), 32'd0);
      @(posedge Clk); #1;
      edges++;
    end
    chk("latency", 32'(edges), 32'(lat));
    for (int k = 0; k < 3; k++)
      model(nd_of(k), v, dec, blz, exp_dig[k], exp_en[k], exp_ovf[k]);
    check_outputs("commit");
    chk("ready_in_done", 32'({RdyA, RdyB, RdyC}), 32'h7);
    chk("done_all", 32'({DoneA, DoneB, DoneC}), 32'h7);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic dec, blz;
    Reset = 1'b1; Load = 1'b0; Value = '0; Decimal = 1'b0; Blank_Lz = 1'b0;
    reset_model();
    repeat (2) @(posedge Clk);
    #1;
    check_outputs("in_reset");
    Reset = 1'b0;
    chk("reset_ready", 32'({RdyA, RdyB, RdyC}), 32'h7);
    chk("reset_done", 32'({DoneA, DoneB, DoneC}), 32'd0);
    idle(5);
    check_outputs("after_idle");

    start(16'h1A3F, 1'b0, 1'b1, 1'b0, '0); finish(16'h1A3F, 1'b0, 1'b1);
    idle(1);
    start(16'd12345, 1'b1, 1'b0, 1'b0, '0); finish(16'd12345, 1'b1, 1'b0);
    start(16'd65535, 1'b1, 1'b1, 1'b0, '0); finish(16'd65535, 1'b1, 1'b1);
    start(16'd0, 1'b1, 1'b1, 1'b0, '0);     finish(16'd0, 1'b1, 1'b1);
    idle(2);

    // Load held high for the whole conversion of 42; the one in the Done cycle wins.
    start(16'd42, 1'b1, 1'b1, 1'b1, 16'd999); finish(16'd42, 1'b1, 1'b1);
    @(posedge Clk); #1;
    Load = 1'b0;
    chk("done_single_pulse", 32'(DoneA), 32'd0);
    chk("held_load_taken", 32'(RdyA), 32'd0);
    finish(16'd999, 1'b1, 1'b0);
    idle(1);

    // Asynchronous reset in the middle of a decimal conversion.
    start(16'd12345, 1'b1, 1'b0, 1'b0, '0);
    repeat (8) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    reset_model();
    check_outputs("mid_reset");
    chk("mid_reset_ready", 32'({RdyA, RdyB, RdyC}), 32'h7);
    chk("mid_reset_done", 32'({DoneA, DoneB, DoneC}), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(W + 4);
    start(16'd12345, 1'b1, 1'b0, 1'b0, '0); finish(16'd12345, 1'b1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 5))
        0:       v = '0;
        1:       v = '1;
        default: v = W'($urandom);
      endcase
      dec = 1'($urandom);
      blz = 1'($urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      start(v, dec, blz, 1'b0, '0);
      finish(v, dec, blz);
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
